ysyx_24100006_axi_bridge: RTL and testbench
===========================================

YSYX_24100006_AXI_BRIDGE -- requirements
Module: ysyx_24100006_axi_bridge

Interface
REQ-001 AXI_DATA_WIDTH, 32, data bus width; legal values 32 or 64.
REQ-002 AXI_ADDR_WIDTH, 32, address width.
REQ-003 AXI_ID_WIDTH, 4, ID field width.
REQ-004 AXI_ID, 0, constant ID driven on io_master_arid_o/io_master_awid_o and expected on rid/bid.
REQ-005 TIMEOUT_CYCLES, 1024, watchdog limit; used only with the Configuration macro.
REQ-006 clk  input  1  single clock; all state changes on rising edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 CPU AR: axi_arvalid_i in 1; axi_arready_o out 1; axi_araddr_i in ADDR; axi_arlen_i in 8; axi_arsize_i in 3.
REQ-009 CPU R: axi_rvalid_o out 1; axi_rready_i in 1; axi_rdata_o out DATA; axi_rresp_o out 2; axi_rlast_o out 1.
REQ-010 CPU AW: axi_awvalid_i in 1; axi_awready_o out 1; axi_awaddr_i in ADDR; axi_awlen_i in 8; axi_awsize_i in 3.
REQ-011 CPU W: axi_wvalid_i in 1; axi_wready_o out 1; axi_wdata_i in DATA; axi_wstrb_i in DATA/8.
REQ-012 CPU B: axi_bvalid_o out 1; axi_bready_i in 1; axi_bresp_o out 2.
REQ-013 Master AW: io_master_awready_i in; io_master_aw{valid,addr,id,len,size,burst}_o out, widths 1/ADDR/ID/8/3/2.
REQ-014 Master W: io_master_wready_i in; io_master_w{valid,data,strb,last}_o out, widths 1/DATA/DATA/8/1.
REQ-015 Master B: io_master_bready_o out; io_master_b{valid,resp,id}_i in, widths 1/2/ID.
REQ-016 Master AR: io_master_arready_i in; io_master_ar{valid,addr,id,len,size,burst}_o out, widths as AW.
REQ-017 Master R: io_master_rready_o out; io_master_r{valid,resp,data,last,id}_i in, widths 1/2/DATA/1/ID.

Function
REQ-018 Read FSM R_IDLE->R_ADDR->R_DATA->R_IDLE and write FSM W_IDLE->W_ADDR->W_DATA->W_RESP->W_IDLE shall run independently; simultaneous read and write are legal.
REQ-019 axi_arready_o shall be 1 only in R_IDLE; on handshake addr/len/size are registered and R_ADDR is entered next cycle.
REQ-020 In R_ADDR io_master_arvalid_o=1 with stable registered payload, arburst=2'b01 (INCR); on io_master_arready_i go R_DATA.
REQ-021 In R_DATA rvalid/rdata/rready pass through combinationally; an 8-bit beat counter increments per R handshake; axi_rlast_o=1 when counter==registered arlen.
REQ-022 On any R beat where io_master_rlast_i != generated last, or rid != AXI_ID, axi_rresp_o shall be 2'b10 (SLVERR); otherwise rresp passes unchanged.
REQ-023 R_DATA->R_IDLE on the handshake of the generated-last beat; arlen=0 completes after one beat.
REQ-024 axi_awready_o=1 only in W_IDLE; W_ADDR drives io_master_awvalid_o with registered payload, awburst=2'b01, until io_master_awready_i.
REQ-025 axi_wready_o=0 outside W_DATA; in W_DATA wvalid/wready/wdata/wstrb pass through; io_master_wlast_o=1 when beat counter==registered awlen; last handshake -> W_RESP.
REQ-026 In W_RESP bvalid/bready pass through; bid != AXI_ID forces axi_bresp_o=2'b10; B handshake -> W_IDLE.
REQ-027 No combinational path from any CPU valid to io_master_arvalid_o/io_master_awvalid_o (one-cycle address latency minimum).

Reset
REQ-028 While reset=1 all valid/ready/last outputs are 0, FSMs idle, counters and payload registers 0; axi_arready_o/axi_awready_o rise the cycle after reset deasserts.
REQ-029 Reset mid-burst abandons the transaction; no CPU response is emitted for it.

Configuration
REQ-030 With YSYX_24100006_AXI_TIMEOUT_EN defined, a per-FSM counter counts consecutive cycles in R_DATA/W_RESP without a slave beat; at TIMEOUT_CYCLES the bridge itself presents one CPU beat with resp=2'b11 (DECERR) and last=1, then returns idle.
REQ-031 Without the macro no counter logic exists and the bridge waits indefinitely.

Structure
REQ-032 Package ysyx_24100006_axi_pkg holds burst codes (FIXED/INCR/WRAP), resp codes (OKAY 00, EXOKAY 01, SLVERR 10, DECERR 11) and both FSM state enums.
REQ-033 Sub-module ysyx_24100006_axi_beat_cnt (load, increment, last-compare) is instantiated once per direction.

Verification
REQ-034 Read arlen=3, addr 0x8000_0000, slave rlast on beat 3 -> four CPU beats, rlast only on 4th, resp 00, FSM idle next cycle.
REQ-035 Write awlen=0, wstrb 4'b0011 -> io_master_wlast_o=1 on first beat, B resp 00 returned.
REQ-036 Slave asserts rlast on beat 1 of arlen=2 -> beat 1 resp 10; read completes after beat 3.
REQ-037 Concurrent read and write issued same cycle -> both complete, ordering of channels independent.
REQ-038 Reset asserted during write beat 2 of 4 -> no axi_bvalid_o, awready_o=1 first cycle after reset.
REQ-039 Macro on, TIMEOUT_CYCLES=16, slave never returns B -> axi_bvalid_o with resp 11 after 16 cycles in W_RESP.

Source files
------------

// File: rtl/ysyx_24100006_axi_pkg.sv
// Shared AXI codes and FSM state types for the CPU-to-master AXI bridge.
package ysyx_24100006_axi_pkg;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10
    } burst_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_e;
    typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} w_state_e;

endpackage

// File: rtl/ysyx_24100006_axi_beat_cnt.sv
// Burst beat counter: load captures the burst length and clears the count,
// inc advances per data handshake, last flags the final beat.
module ysyx_24100006_axi_beat_cnt (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic       inc,
    input  logic [7:0] len_in,
    output logic [7:0] len,
    output logic       last
);
    logic [7:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
            len   <= '0;
        end else if (load) begin
            count <= '0;
            len   <= len_in;
        end else if (inc) begin
            count <= count + 8'd1;
        end
    end

    assign last = (count == len);
endmodule

// File: rtl/ysyx_24100006_axi_bridge.sv
// CPU-side AXI to master AXI bridge with independent read and write FSMs.
// Optional watchdog: define YSYX_24100006_AXI_TIMEOUT_EN.
//   state  | meaning
//   R_IDLE | accepting CPU AR        W_IDLE | accepting CPU AW
//   R_ADDR | presenting master AR    W_ADDR | presenting master AW
//   R_DATA | R beats pass through    W_DATA | W beats pass through
//                                    W_RESP | waiting for B
module ysyx_24100006_axi_bridge
    import ysyx_24100006_axi_pkg::*;
#(
    parameter int AXI_DATA_WIDTH = 32,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_ID_WIDTH   = 4,
    parameter int AXI_ID         = 0,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        axi_arvalid_i,
    output logic                        axi_arready_o,
    input  logic [AXI_ADDR_WIDTH-1:0]   axi_araddr_i,
    input  logic [7:0]                  axi_arlen_i,
    input  logic [2:0]                  axi_arsize_i,
    output logic                        axi_rvalid_o,
    input  logic                        axi_rready_i,
    output logic [AXI_DATA_WIDTH-1:0]   axi_rdata_o,
    output logic [1:0]                  axi_rresp_o,
    output logic                        axi_rlast_o,
    input  logic                        axi_awvalid_i,
    output logic                        axi_awready_o,
    input  logic [AXI_ADDR_WIDTH-1:0]   axi_awaddr_i,
    input  logic [7:0]                  axi_awlen_i,
    input  logic [2:0]                  axi_awsize_i,
    input  logic                        axi_wvalid_i,
    output logic                        axi_wready_o,
    input  logic [AXI_DATA_WIDTH-1:0]   axi_wdata_i,
    input  logic [AXI_DATA_WIDTH/8-1:0] axi_wstrb_i,
    output logic                        axi_bvalid_o,
    input  logic                        axi_bready_i,
    output logic [1:0]                  axi_bresp_o,
    input  logic                        io_master_awready_i,
    output logic                        io_master_awvalid_o,
    output logic [AXI_ADDR_WIDTH-1:0]   io_master_awaddr_o,
    output logic [AXI_ID_WIDTH-1:0]     io_master_awid_o,
    output logic [7:0]                  io_master_awlen_o,
    output logic [2:0]                  io_master_awsize_o,
    output logic [1:0]                  io_master_awburst_o,
    input  logic                        io_master_wready_i,
    output logic                        io_master_wvalid_o,
    output logic [AXI_DATA_WIDTH-1:0]   io_master_wdata_o,
    output logic [AXI_DATA_WIDTH/8-1:0] io_master_wstrb_o,
    output logic                        io_master_wlast_o,
    output logic                        io_master_bready_o,
    input  logic                        io_master_bvalid_i,
    input  logic [1:0]                  io_master_bresp_i,
    input  logic [AXI_ID_WIDTH-1:0]     io_master_bid_i,
    input  logic                        io_master_arready_i,
    output logic                        io_master_arvalid_o,
    output logic [AXI_ADDR_WIDTH-1:0]   io_master_araddr_o,
    output logic [AXI_ID_WIDTH-1:0]     io_master_arid_o,
    output logic [7:0]                  io_master_arlen_o,
    output logic [2:0]                  io_master_arsize_o,
    output logic [1:0]                  io_master_arburst_o,
    output logic                        io_master_rready_o,
    input  logic                        io_master_rvalid_i,
    input  logic [1:0]                  io_master_rresp_i,
    input  logic [AXI_DATA_WIDTH-1:0]   io_master_rdata_i,
    input  logic                        io_master_rlast_i,
    input  logic [AXI_ID_WIDTH-1:0]     io_master_rid_i
);
    localparam logic [AXI_ID_WIDTH-1:0] ID_VAL = AXI_ID_WIDTH'(AXI_ID);

    r_state_e                  r_state;
    w_state_e                  w_state;
    logic                      run;
    logic                      arready_q, m_arvalid_q, awready_q, m_awvalid_q;
    logic [AXI_ADDR_WIDTH-1:0] ar_addr, aw_addr;
    logic [2:0]                ar_size, aw_size;
    logic                      r_in_data, w_in_data, w_in_resp;
    logic                      r_gen_last, w_gen_last, r_to, w_to;
    logic                      r_ar_hs, r_slave_beat, r_cpu_done;
    logic                      w_aw_hs, w_beat, w_slave_b, w_cpu_done;

    // Outputs are forced quiet while reset is held, before the first edge lands.
    assign run       = ~reset;
    assign r_in_data = (r_state == R_DATA);
    assign w_in_data = (w_state == W_DATA);
    assign w_in_resp = (w_state == W_RESP);

    assign axi_arready_o       = run & arready_q;
    assign io_master_arvalid_o = run & m_arvalid_q;
    assign io_master_araddr_o  = ar_addr;
    assign io_master_arid_o    = ID_VAL;
    assign io_master_arsize_o  = ar_size;
    assign io_master_arburst_o = BURST_INCR;

    assign r_ar_hs      = axi_arvalid_i & axi_arready_o;
    assign r_slave_beat = r_in_data & ~r_to & io_master_rvalid_i & axi_rready_i;
    assign io_master_rready_o = run & r_in_data & ~r_to & axi_rready_i;
    assign axi_rvalid_o = run & r_in_data & (r_to | io_master_rvalid_i);
    assign axi_rlast_o  = run & r_in_data & (r_to | r_gen_last);
    assign axi_rdata_o  = r_to ? '0 : io_master_rdata_i;
    assign axi_rresp_o  = r_to ? RESP_DECERR :
                          ((io_master_rlast_i != r_gen_last) || (io_master_rid_i != ID_VAL)) ?
                          RESP_SLVERR : io_master_rresp_i;
    assign r_cpu_done   = axi_rvalid_o & axi_rready_i & axi_rlast_o;

    assign axi_awready_o       = run & awready_q;
    assign io_master_awvalid_o = run & m_awvalid_q;
    assign io_master_awaddr_o  = aw_addr;
    assign io_master_awid_o    = ID_VAL;
    assign io_master_awsize_o  = aw_size;
    assign io_master_awburst_o = BURST_INCR;

    assign w_aw_hs            = axi_awvalid_i & axi_awready_o;
    assign w_beat             = w_in_data & axi_wvalid_i & io_master_wready_i;
    assign io_master_wvalid_o = run & w_in_data & axi_wvalid_i;
    assign axi_wready_o       = run & w_in_data & io_master_wready_i;
    assign io_master_wdata_o  = axi_wdata_i;
    assign io_master_wstrb_o  = axi_wstrb_i;
    assign io_master_wlast_o  = run & w_in_data & w_gen_last;

    assign w_slave_b          = w_in_resp & ~w_to & io_master_bvalid_i & axi_bready_i;
    assign io_master_bready_o = run & w_in_resp & ~w_to & axi_bready_i;
    assign axi_bvalid_o       = run & w_in_resp & (w_to | io_master_bvalid_i);
    assign axi_bresp_o        = w_to ? RESP_DECERR :
                                (io_master_bid_i != ID_VAL) ? RESP_SLVERR : io_master_bresp_i;
    assign w_cpu_done         = axi_bvalid_o & axi_bready_i;

    ysyx_24100006_axi_beat_cnt u_r_cnt (
        .clk(clk), .reset(reset), .load(r_ar_hs), .inc(r_slave_beat),
        .len_in(axi_arlen_i), .len(io_master_arlen_o), .last(r_gen_last)
    );

    ysyx_24100006_axi_beat_cnt u_w_cnt (
        .clk(clk), .reset(reset), .load(w_aw_hs), .inc(w_beat),
        .len_in(axi_awlen_i), .len(io_master_awlen_o), .last(w_gen_last)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= R_IDLE;
            arready_q   <= 1'b0;
            m_arvalid_q <= 1'b0;
            ar_addr     <= '0;
            ar_size     <= '0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    arready_q <= 1'b1;
                    if (r_ar_hs) begin
                        ar_addr     <= axi_araddr_i;
                        ar_size     <= axi_arsize_i;
                        arready_q   <= 1'b0;
                        m_arvalid_q <= 1'b1;
                        r_state     <= R_ADDR;
                    end
                end
                R_ADDR: if (io_master_arready_i) begin
                    m_arvalid_q <= 1'b0;
                    r_state     <= R_DATA;
                end
                R_DATA: if (r_cpu_done) begin
                    arready_q <= 1'b1;
                    r_state   <= R_IDLE;
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            w_state     <= W_IDLE;
            awready_q   <= 1'b0;
            m_awvalid_q <= 1'b0;
            aw_addr     <= '0;
            aw_size     <= '0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    awready_q <= 1'b1;
                    if (w_aw_hs) begin
                        aw_addr     <= axi_awaddr_i;
                        aw_size     <= axi_awsize_i;
                        awready_q   <= 1'b0;
                        m_awvalid_q <= 1'b1;
                        w_state     <= W_ADDR;
                    end
                end
                W_ADDR: if (io_master_awready_i) begin
                    m_awvalid_q <= 1'b0;
                    w_state     <= W_DATA;
                end
                W_DATA: if (w_beat && w_gen_last) w_state <= W_RESP;
                W_RESP: if (w_cpu_done) begin
                    awready_q <= 1'b1;
                    w_state   <= W_IDLE;
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

`ifdef YSYX_24100006_AXI_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] r_tmr, w_tmr;
    logic          r_to_q, w_to_q;

    // Watchdogs count consecutive beat-less cycles; once fired they hold until the
    // FSM leaves the waiting state.
    always_ff @(posedge clk) begin
        if (reset || !r_in_data) begin
            r_tmr  <= '0;
            r_to_q <= 1'b0;
        end else if (!r_to_q) begin
            if (r_slave_beat)                          r_tmr  <= '0;
            else if (r_tmr == TW'(TIMEOUT_CYCLES - 1)) r_to_q <= 1'b1;
            else                                       r_tmr  <= r_tmr + TW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset || !w_in_resp) begin
            w_tmr  <= '0;
            w_to_q <= 1'b0;
        end else if (!w_to_q) begin
            if (w_slave_b)                             w_tmr  <= '0;
            else if (w_tmr == TW'(TIMEOUT_CYCLES - 1)) w_to_q <= 1'b1;
            else                                       w_tmr  <= w_tmr + TW'(1);
        end
    end

    assign r_to = r_to_q & r_in_data;
    assign w_to = w_to_q & w_in_resp;
`else
    assign r_to = 1'b0;
    assign w_to = 1'b0;
`endif
endmodule

// File: tb/tb_ysyx_24100006_axi_bridge.sv
// Directed + randomized bench for the AXI bridge; the watchdog case runs only
// when YSYX_24100006_AXI_TIMEOUT_EN is defined.
module tb_ysyx_24100006_axi_bridge;
`ifdef YSYX_24100006_AXI_TIMEOUT_EN
    localparam int TO = 16;
`else
    localparam int TO = 1024;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        axi_arvalid_i, axi_arready_o, axi_rvalid_o, axi_rready_i, axi_rlast_o;
    logic [31:0] axi_araddr_i, axi_rdata_o, axi_awaddr_i, axi_wdata_i;
    logic [7:0]  axi_arlen_i, axi_awlen_i;
    logic [2:0]  axi_arsize_i, axi_awsize_i;
    logic [1:0]  axi_rresp_o, axi_bresp_o;
    logic        axi_awvalid_i, axi_awready_o, axi_wvalid_i, axi_wready_o;
    logic [3:0]  axi_wstrb_i;
    logic        axi_bvalid_o, axi_bready_i;
    logic        io_master_awready_i, io_master_awvalid_o, io_master_wready_i, io_master_wvalid_o;
    logic [31:0] io_master_awaddr_o, io_master_araddr_o, io_master_wdata_o, io_master_rdata_i;
    logic [3:0]  io_master_awid_o, io_master_arid_o, io_master_bid_i, io_master_rid_i;
    logic [7:0]  io_master_awlen_o, io_master_arlen_o;
    logic [2:0]  io_master_awsize_o, io_master_arsize_o;
    logic [1:0]  io_master_awburst_o, io_master_arburst_o, io_master_bresp_i, io_master_rresp_i;
    logic [3:0]  io_master_wstrb_o;
    logic        io_master_wlast_o, io_master_bready_o, io_master_bvalid_i;
    logic        io_master_arready_i, io_master_arvalid_o, io_master_rready_o;
    logic        io_master_rvalid_i, io_master_rlast_i;

    int total = 0;
    int bad   = 0;

    ysyx_24100006_axi_bridge #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset),
        .axi_arvalid_i(axi_arvalid_i), .axi_arready_o(axi_arready_o), .axi_araddr_i(axi_araddr_i),
        .axi_arlen_i(axi_arlen_i), .axi_arsize_i(axi_arsize_i),
        .axi_rvalid_o(axi_rvalid_o), .axi_rready_i(axi_rready_i), .axi_rdata_o(axi_rdata_o),
        .axi_rresp_o(axi_rresp_o), .axi_rlast_o(axi_rlast_o),
        .axi_awvalid_i(axi_awvalid_i), .axi_awready_o(axi_awready_o), .axi_awaddr_i(axi_awaddr_i),
        .axi_awlen_i(axi_awlen_i), .axi_awsize_i(axi_awsize_i),
        .axi_wvalid_i(axi_wvalid_i), .axi_wready_o(axi_wready_o), .axi_wdata_i(axi_wdata_i),
        .axi_wstrb_i(axi_wstrb_i),
        .axi_bvalid_o(axi_bvalid_o), .axi_bready_i(axi_bready_i), .axi_bresp_o(axi_bresp_o),
        .io_master_awready_i(io_master_awready_i), .io_master_awvalid_o(io_master_awvalid_o),
        .io_master_awaddr_o(io_master_awaddr_o), .io_master_awid_o(io_master_awid_o),
        .io_master_awlen_o(io_master_awlen_o), .io_master_awsize_o(io_master_awsize_o),
        .io_master_awburst_o(io_master_awburst_o),
        .io_master_wready_i(io_master_wready_i), .io_master_wvalid_o(io_master_wvalid_o),
        .io_master_wdata_o(io_master_wdata_o), .io_master_wstrb_o(io_master_wstrb_o),
        .io_master_wlast_o(io_master_wlast_o),
        .io_master_bready_o(io_master_bready_o), .io_master_bvalid_i(io_master_bvalid_i),
        .io_master_bresp_i(io_master_bresp_i), .io_master_bid_i(io_master_bid_i),
        .io_master_arready_i(io_master_arready_i), .io_master_arvalid_o(io_master_arvalid_o),
        .io_master_araddr_o(io_master_araddr_o), .io_master_arid_o(io_master_arid_o),
        .io_master_arlen_o(io_master_arlen_o), .io_master_arsize_o(io_master_arsize_o),
        .io_master_arburst_o(io_master_arburst_o),
        .io_master_rready_o(io_master_rready_o), .io_master_rvalid_i(io_master_rvalid_i),
        .io_master_rresp_i(io_master_rresp_i), .io_master_rdata_i(io_master_rdata_i),
        .io_master_rlast_i(io_master_rlast_i), .io_master_rid_i(io_master_rid_i)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One read burst. bad_beat >= 0 makes the slave raise rlast on that beat only.
    task automatic do_read(input logic [31:0] addr, input logic [7:0] len,
                           input int bad_beat, input bit rnd);
        int cyc, b, dly;
        logic rv, rr, rl;
        logic [31:0] d;
        logic [3:0] id;
        logic [1:0] rs, er;
        axi_arvalid_i = 1'b1; axi_araddr_i = addr; axi_arlen_i = len; axi_arsize_i = 3'd2;
        #1;
        chk("ar_no_comb_path", io_master_arvalid_o, 1'b0);
        cyc = 0;
        while (!axi_arready_o && cyc < 50) begin @(negedge clk); #1; cyc++; end
        chk("ar_accept_in_time", cyc < 50, 1'b1);
        @(negedge clk);
        axi_arvalid_i = 1'b0; axi_araddr_i = $urandom; axi_arlen_i = 8'($urandom);
        #1;
        dly = rnd ? $urandom_range(0, 2) : 0;
        for (int i = 0; i <= dly; i++) begin
            chk("m_arvalid", io_master_arvalid_o, 1'b1);
            chk("m_araddr", io_master_araddr_o, addr);
            chk("m_arlen", io_master_arlen_o, len);
            if (i == 0) begin
                chk("m_arsize", io_master_arsize_o, 3'd2);
                chk("m_arburst", io_master_arburst_o, 2'b01);
                chk("m_arid", io_master_arid_o, 4'd0);
            end
            if (i == dly) io_master_arready_i = 1'b1;
            @(negedge clk); #1;
        end
        io_master_arready_i = 1'b0;
        b = 0; cyc = 0;
        while (b <= int'(len) && cyc < 300) begin
            rv = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            rr = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            d  = $urandom;
            rl = (bad_beat >= 0) ? (b == bad_beat) : (b == int'(len));
            id = (rnd && $urandom_range(0, 7) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
            rs = rnd ? 2'($urandom_range(0, 1)) : 2'b00;
            io_master_rvalid_i = rv; axi_rready_i = rr; io_master_rdata_i = d;
            io_master_rlast_i = rl; io_master_rid_i = id; io_master_rresp_i = rs;
            #1;
            chk("r_valid_pass", axi_rvalid_o, rv);
            chk("r_ready_pass", io_master_rready_o, rr);
            if (rv && rr) begin
                er = ((rl != (b == int'(len))) || id != 4'd0) ? 2'b10 : rs;
                chk("r_data", axi_rdata_o, d);
                chk("r_last", axi_rlast_o, b == int'(len));
                chk("r_resp", axi_rresp_o, er);
                b++;
            end
            @(negedge clk);
            cyc++;
        end
        io_master_rvalid_i = 1'b0; axi_rready_i = 1'b0; io_master_rlast_i = 1'b0;
        chk("r_beats_done", b, int'(len) + 1);
        #1;
        chk("r_idle_after_last", axi_arready_o, 1'b1);
    endtask

    // One write burst. abort_at >= 0 pulses reset before that beat; skip_b leaves
    // the bridge waiting in the response phase with no checks on B.
    task automatic do_write(input logic [31:0] addr, input logic [7:0] len, input logic [3:0] strb,
                            input bit rnd, input int abort_at, input bit skip_b);
        int cyc, b;
        bit aborted, done;
        logic wv, wr, bv, br;
        logic [31:0] d;
        logic [3:0] s, id;
        logic [1:0] rs, eb;
        axi_awvalid_i = 1'b1; axi_awaddr_i = addr; axi_awlen_i = len; axi_awsize_i = 3'd2;
        #1;
        chk("aw_no_comb_path", io_master_awvalid_o, 1'b0);
        cyc = 0;
        while (!axi_awready_o && cyc < 50) begin @(negedge clk); #1; cyc++; end
        chk("aw_accept_in_time", cyc < 50, 1'b1);
        @(negedge clk);
        axi_awvalid_i = 1'b0; axi_awaddr_i = $urandom;
        #1;
        chk("m_awvalid", io_master_awvalid_o, 1'b1);
        chk("m_awaddr", io_master_awaddr_o, addr);
        chk("m_awlen", io_master_awlen_o, len);
        chk("m_awburst", io_master_awburst_o, 2'b01);
        chk("m_awid", io_master_awid_o, 4'd0);
        chk("w_ready_blocked", axi_wready_o, 1'b0);
        io_master_awready_i = 1'b1;
        @(negedge clk); #1;
        io_master_awready_i = 1'b0;
        b = 0; cyc = 0; aborted = 1'b0;
        while (b <= int'(len) && cyc < 300) begin
            if (b == abort_at) begin aborted = 1'b1; break; end
            wv = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            wr = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            d  = $urandom;
            s  = rnd ? 4'($urandom) : strb;
            axi_wvalid_i = wv; io_master_wready_i = wr; axi_wdata_i = d; axi_wstrb_i = s;
            #1;
            chk("w_valid_pass", io_master_wvalid_o, wv);
            chk("w_ready_pass", axi_wready_o, wr);
            if (wv && wr) begin
                chk("w_data", io_master_wdata_o, d);
                chk("w_strb", io_master_wstrb_o, s);
                chk("w_last", io_master_wlast_o, b == int'(len));
                b++;
            end
            @(negedge clk);
            cyc++;
        end
        if (aborted) begin
            reset = 1'b1; io_master_bvalid_i = 1'b1; axi_bready_i = 1'b1;
            io_master_bid_i = 4'd0; io_master_bresp_i = 2'b00;
            repeat (2) begin
                @(negedge clk); #1;
                chk("rst_bvalid", axi_bvalid_o, 1'b0);
                chk("rst_awready", axi_awready_o, 1'b0);
                chk("rst_m_wvalid", io_master_wvalid_o, 1'b0);
                chk("rst_m_wlast", io_master_wlast_o, 1'b0);
            end
            reset = 1'b0; axi_wvalid_i = 1'b0; io_master_wready_i = 1'b0;
            for (int i = 0; i < 3; i++) begin
                @(negedge clk); #1;
                if (i == 0) chk("post_rst_awready", axi_awready_o, 1'b1);
                chk("post_rst_no_bvalid", axi_bvalid_o, 1'b0);
            end
            io_master_bvalid_i = 1'b0; axi_bready_i = 1'b0;
            return;
        end
        axi_wvalid_i = 1'b0; io_master_wready_i = 1'b0;
        chk("w_beats_done", b, int'(len) + 1);
        if (skip_b) return;
        done = 1'b0; cyc = 0;
        while (!done && cyc < 100) begin
            bv = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
            br = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
            id = (rnd && $urandom_range(0, 5) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
            rs = rnd ? 2'($urandom_range(0, 1)) : 2'b00;
            io_master_bvalid_i = bv; axi_bready_i = br; io_master_bid_i = id; io_master_bresp_i = rs;
            #1;
            chk("b_valid_pass", axi_bvalid_o, bv);
            chk("b_ready_pass", io_master_bready_o, br);
            if (bv && br) begin
                eb = (id != 4'd0) ? 2'b10 : rs;
                chk("b_resp", axi_bresp_o, eb);
                done = 1'b1;
            end
            @(negedge clk);
            cyc++;
        end
        io_master_bvalid_i = 1'b0; axi_bready_i = 1'b0;
        chk("b_done", done, 1'b1);
        #1;
        chk("w_idle_after_b", axi_awready_o, 1'b1);
    endtask

    initial begin
        int k;
        reset = 1'b1;
        axi_arvalid_i = 0; axi_araddr_i = 0; axi_arlen_i = 0; axi_arsize_i = 0; axi_rready_i = 0;
        axi_awvalid_i = 0; axi_awaddr_i = 0; axi_awlen_i = 0; axi_awsize_i = 0;
        axi_wvalid_i = 0; axi_wdata_i = 0; axi_wstrb_i = 0; axi_bready_i = 0;
        io_master_awready_i = 0; io_master_wready_i = 0; io_master_bvalid_i = 0;
        io_master_bresp_i = 0; io_master_bid_i = 0; io_master_arready_i = 0;
        io_master_rvalid_i = 0; io_master_rresp_i = 0; io_master_rdata_i = 0;
        io_master_rlast_i = 0; io_master_rid_i = 0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_arready", axi_arready_o, 1'b0);
        chk("rst_awready", axi_awready_o, 1'b0);
        chk("rst_rvalid", axi_rvalid_o, 1'b0);
        chk("rst_rlast", axi_rlast_o, 1'b0);
        chk("rst_bvalid", axi_bvalid_o, 1'b0);
        chk("rst_wready", axi_wready_o, 1'b0);
        chk("rst_m_arvalid", io_master_arvalid_o, 1'b0);
        chk("rst_m_awvalid", io_master_awvalid_o, 1'b0);
        chk("rst_m_wvalid", io_master_wvalid_o, 1'b0);
        chk("rst_m_rready", io_master_rready_o, 1'b0);
        chk("rst_m_araddr", io_master_araddr_o, 32'd0);
        chk("rst_m_arlen", io_master_arlen_o, 8'd0);
        reset = 1'b0;
        @(negedge clk); #1;
        chk("arready_after_rst", axi_arready_o, 1'b1);
        chk("awready_after_rst", axi_awready_o, 1'b1);

        do_read(32'h8000_0000, 8'd3, -1, 1'b0);
        do_write($urandom, 8'd0, 4'b0011, 1'b0, -1, 1'b0);
        do_read($urandom, 8'd2, 1, 1'b0);
        for (int i = 0; i < 8; i++) begin
            if ($urandom_range(0, 1) == 0) do_read($urandom, 8'($urandom_range(0, 5)), -1, 1'b1);
            else do_write($urandom, 8'($urandom_range(0, 5)), 4'hf, 1'b1, -1, 1'b0);
        end
        fork
            do_read($urandom, 8'($urandom_range(1, 4)), -1, 1'b1);
            do_write($urandom, 8'($urandom_range(1, 4)), 4'hf, 1'b1, -1, 1'b0);
        join
        do_write($urandom, 8'd3, 4'hf, 1'b0, 2, 1'b0);
        do_read($urandom, 8'd1, -1, 1'b1);

`ifdef YSYX_24100006_AXI_TIMEOUT_EN
        do_write($urandom, 8'd0, 4'hf, 1'b0, -1, 1'b1);
        axi_bready_i = 1'b1; io_master_bvalid_i = 1'b0;
        #1;
        k = 0;
        while (!axi_bvalid_o && k < 100) begin @(negedge clk); #1; k++; end
        chk("to_cycles", k, 16);
        chk("to_bresp", axi_bresp_o, 2'b11);
        @(negedge clk); #1;
        axi_bready_i = 1'b0;
        chk("to_idle_awready", axi_awready_o, 1'b1);
        chk("to_bvalid_clear", axi_bvalid_o, 1'b0);
`else
        k = 0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
